// File: rtl/branch_ctrl_pkg.sv
// Shared types and constants for the branch PC sequencer: state encoding,
// default datapath parameters and the flush counter sizing helper.
package branch_ctrl_pkg;

  localparam int          DEF_XLEN     = 32;
  localparam int          DEF_INC      = 4;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_SEQ   = 2'd0,
    ST_CALC  = 2'd1,
    ST_FLUSH = 2'd2
  } seq_state_e;

  // At least one bit so the counter stays declarable when FLUSH_CYCLES is 1 or 2.
  function automatic int flush_cnt_width(input int cycles);
    if (cycles <= 2) begin
      return 1;
    end else begin
      return $clog2(cycles);
    end
  endfunction

endpackage

// File: rtl/Branch_Adder.sv
// Branch target adder: PC plus a signed byte offset, wrapping modulo 2^XLEN.
module Branch_Adder #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] PC,
  input  logic [XLEN-1:0] offset,
  output logic [XLEN-1:0] branch_target
);

  assign branch_target = PC + offset;

endmodule

// File: rtl/branch_pc_sequencer.sv
// Fetch PC owner: sequential increment or taken-branch redirect through one
// shared adder, with a fixed-length flush window after every redirect.
module branch_pc_sequencer
  import branch_ctrl_pkg::*;
#(
  parameter int              XLEN         = DEF_XLEN,
  parameter logic [XLEN-1:0] RESET_PC     = XLEN'(DEF_RESET_PC),
  parameter int              INC          = DEF_INC,
  parameter int              FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            br_valid,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_pc,
  input  logic [XLEN-1:0] br_offset,
  output logic            br_ready,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic            flush,
  output logic            align_err
);

  localparam int              CNT_W    = flush_cnt_width(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = (FLUSH_CYCLES > 1) ? CNT_W'(FLUSH_CYCLES - 2) : {CNT_W{1'b0}};
  localparam logic [XLEN-1:0]  INC_V    = XLEN'(INC);

  seq_state_e       state_r;
  seq_state_e       state_nxt_s;
  logic [XLEN-1:0]  pc_r;
  logic [XLEN-1:0]  br_pc_r;
  logic [XLEN-1:0]  br_off_r;
  logic [CNT_W-1:0] cnt_r;
  logic [XLEN-1:0]  opa_s;
  logic [XLEN-1:0]  opb_s;
  logic [XLEN-1:0]  sum_s;
  logic             take_s;

  assign take_s = br_valid && br_taken;

  // Operand mux feeding the single shared adder, selected by state.
  always_comb begin
    opa_s = pc_r;
    opb_s = INC_V;
    case (state_r)
      ST_CALC: begin
        opa_s = br_pc_r;
        opb_s = br_off_r;
      end
      ST_SEQ, ST_FLUSH: begin
        opa_s = pc_r;
        opb_s = INC_V;
      end
      default: begin
        opa_s = pc_r;
        opb_s = INC_V;
      end
    endcase
  end

  Branch_Adder #(
    .XLEN(XLEN)
  ) u_adder (
    .PC           (opa_s),
    .offset       (opb_s),
    .branch_target(sum_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_SEQ;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_SEQ: begin
        if (take_s) begin
          state_nxt_s = ST_CALC;
        end else begin
          state_nxt_s = ST_SEQ;
        end
      end
      ST_CALC: begin
        if (FLUSH_CYCLES == 1) begin
          state_nxt_s = ST_SEQ;
        end else begin
          state_nxt_s = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_nxt_s = ST_SEQ;
        end else begin
          state_nxt_s = ST_FLUSH;
        end
      end
      default: state_nxt_s = ST_SEQ;
    endcase
  end

  // Moore output decode; align_err looks at the redirect sum while in CALC.
  always_comb begin
    br_ready  = 1'b0;
    pc_valid  = 1'b0;
    flush     = 1'b0;
    align_err = 1'b0;
    case (state_r)
      ST_SEQ: begin
        br_ready = 1'b1;
        pc_valid = 1'b1;
      end
      ST_CALC: begin
        flush = 1'b1;
        if ((sum_s % INC_V) != {XLEN{1'b0}}) begin
          align_err = 1'b1;
        end else begin
          align_err = 1'b0;
        end
      end
      ST_FLUSH: begin
        flush = 1'b1;
      end
      default: begin
        br_ready = 1'b0;
      end
    endcase
  end

  // PC, latched branch operands and flush counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r     <= RESET_PC;
      br_pc_r  <= {XLEN{1'b0}};
      br_off_r <= {XLEN{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_SEQ: begin
          if (take_s) begin
            br_pc_r  <= br_pc;
            br_off_r <= br_offset;
          end else if (!stall) begin
            pc_r <= sum_s;
          end else begin
            pc_r <= pc_r;
          end
        end
        ST_CALC: begin
          pc_r  <= sum_s;
          cnt_r <= CNT_LOAD;
        end
        ST_FLUSH: begin
          if (cnt_r != {CNT_W{1'b0}}) begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            cnt_r <= cnt_r;
          end
        end
        default: begin
          pc_r <= pc_r;
        end
      endcase
    end
  end

  assign pc = pc_r;

endmodule
